// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: default sizing, feeder FSM
// encodings and the FIFO control bundle.
package uart_pkg;

  localparam int UART_DEPTH  = 16;
  localparam int UART_DATA_W = 8;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [ST_W-1:0] ST_SEND      = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [ST_W-1:0] ST_WAIT_DONE = 2'd3;

  typedef struct packed {
    logic push;
    logic pop;
    logic flush;
  } fifo_ctl_t;

  // Next feeder state from the current state and transmitter handshake.
  function automatic logic [ST_W-1:0] feeder_next(input logic [ST_W-1:0] st,
                                                  input logic            start,
                                                  input logic            tx_ready);
    logic [ST_W-1:0] nxt;
    nxt = st;
    case (st)
      ST_IDLE:      if (start)     nxt = ST_SEND;
      ST_SEND:                     nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!tx_ready) nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_ready)  nxt = ST_IDLE;
      default:                     nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-around pointers; head is read combinationally
// so a pop and the byte it removes are available at the same edge.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to a UART transmitter,
// waiting for its ready line to fall and rise between bytes.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   flush,
  output logic                   overflow,
  input  logic                   clr_ovf,
  input  logic                   tx_ready,
  output logic                   send,
  output logic [DATA_W-1:0]      data_out,
  output logic                   idle
);

  logic [ST_W-1:0]       state_q, state_d;
  logic                  send_q, send_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_W-1:0]     head;
  logic                  fifo_full, fifo_empty;
  logic                  start, drop;
  fifo_ctl_t             ctl;

  // Flush beats a pending start so nothing leaves a FIFO being emptied.
  assign start = (state_q == ST_IDLE) && !fifo_empty && tx_ready && !flush;
  assign drop  = wr_en && fifo_full && !start && !flush;

  assign ctl.push  = wr_en;
  assign ctl.pop   = start;
  assign ctl.flush = flush;

  uart_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (ctl.push),
    .pop     (ctl.pop),
    .flush   (ctl.flush),
    .din     (wr_data),
    .dout    (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = feeder_next(state_q, start, tx_ready);
    send_d     = (state_d == ST_SEND);
    data_out_d = start ? head : data_out_q;
    ovf_d      = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      send_q     <= 1'b0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      send_q     <= send_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign full     = fifo_full;
  assign send     = send_q;
  assign data_out = data_out_q;
  assign overflow = ovf_q;
  assign idle     = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized and directed bench for uart_tx_feeder against a queue-based
// reference and a lagging transmitter model.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int LAG   = 2;
  localparam int FRAME = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic [4:0]    count;
  logic          flush = 1'b0;
  logic          overflow;
  logic          clr_ovf = 1'b0;
  logic          tx_ready;
  logic          send;
  logic [DW-1:0] data_out;
  logic          idle;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .count    (count),
    .flush    (flush),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .tx_ready (tx_ready),
    .send     (send),
    .data_out (data_out),
    .idle     (idle)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Transmitter: ready stays high LAG edges after seeing send, then low for FRAME cycles.
  int   lag = 0, busy = 0;
  logic tx_free = 1'b1, tx_hold = 1'b0, snd;
  assign tx_ready = tx_free && !tx_hold;

  always begin
    @(posedge clk);
    snd = send;
    #1;
    if (snd) lag = LAG;
    else if (lag > 0) begin
      lag--;
      if (lag == 0) busy = FRAME;
    end else if (busy > 0) busy--;
    tx_free = (busy == 0);
  end

  // Inputs as seen by the DUT at the last rising edge.
  logic          s_wr = 0, s_flush = 0, s_clr = 0, s_txr = 0, s_rst = 1;
  logic [DW-1:0] s_wd = '0;
  always @(posedge clk) begin
    s_wr    <= wr_en;
    s_wd    <= wr_data;
    s_flush <= flush;
    s_clr   <= clr_ovf;
    s_txr   <= tx_ready;
    s_rst   <= !reset_n;
  end

  // Reference: byte queue, sticky drop flag, and the one-byte-at-a-time handshake.
  logic [DW-1:0] q[$];
  logic [DW-1:0] dout_m = '0;
  logic          ovf_m = 0, engaged = 0, seen_low = 0, just_sent = 0, exp_pop, dropped;

  always @(negedge clk) begin
    if (!reset_n || s_rst) begin
      q.delete();
      dout_m = '0; ovf_m = 0; engaged = 0; seen_low = 0; just_sent = 0;
    end else begin
      exp_pop = !engaged && (q.size() > 0) && s_txr && !s_flush;
      chk("send", int'(send), int'(exp_pop));
      if (engaged) begin
        if (just_sent) just_sent = 0;
        else if (!seen_low) begin
          if (!s_txr) seen_low = 1;
        end else if (s_txr) engaged = 0;
      end
      if (send && q.size() > 0) begin
        dout_m = q.pop_front();
        engaged = 1; just_sent = 1; seen_low = 0;
      end
      dropped = 0;
      if (s_flush) q.delete();
      else if (s_wr) begin
        if (q.size() < DEPTH) q.push_back(s_wd);
        else dropped = 1;
      end
      if (dropped) ovf_m = 1;
      else if (s_clr) ovf_m = 0;
    end
    chk("data_out", int'(data_out), int'(dout_m));
    chk("count", int'(count), q.size());
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("overflow", int'(overflow), int'(ovf_m));
    chk("idle", int'(idle), int'(q.size() == 0 && !engaged));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(idle && tx_ready) && n < budget) begin
      cyc();
      n++;
    end
    chk("idle_timeout", int'(n < budget), 1);
  endtask

  task automatic put(input logic [DW-1:0] b);
    wr_en = 1'b1;
    wr_data = b;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    #400000;
    chk("watchdog", 0, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    logic [DW-1:0] b;
    int n;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_send", int'(send), 0);
    chk("rst_dout", int'(data_out), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_count", int'(count), 0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc(); cyc();

    // single byte: send one edge after the write edge, for exactly one cycle
    wr_en = 1'b1; wr_data = 8'hA5;
    cyc();
    wr_en = 1'b0;
    chk("single_nosend_yet", int'(send), 0);
    cyc();
    chk("single_send", int'(send), 1);
    chk("single_dout", int'(data_out), 8'hA5);
    cyc();
    chk("single_pulse_end", int'(send), 0);
    chk("single_hold", int'(data_out), 8'hA5);
    wait_idle(200);

    // burst 0x01..0x10 with the transmitter held busy, then full-FIFO cases
    tx_hold = 1'b1;
    cyc();
    for (int i = 1; i <= DEPTH; i++) put(DW'(i));
    chk("burst_full", int'(full), 1);
    chk("burst_count", int'(count), DEPTH);
    put(8'hDD);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_count", int'(count), DEPTH);
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    chk("clr_ovf", int'(overflow), 0);
    wr_en = 1'b1; wr_data = 8'hDE; clr_ovf = 1'b1;
    cyc();
    wr_en = 1'b0; clr_ovf = 1'b0;
    chk("set_beats_clr", int'(overflow), 1);
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    wr_en = 1'b1; wr_data = 8'hEE; tx_hold = 1'b0;
    cyc();
    wr_en = 1'b0;
    chk("full_pop_send", int'(send), 1);
    chk("full_pop_dout", int'(data_out), 8'h01);
    chk("full_pop_count", int'(count), DEPTH);
    wait_idle(600);
    chk("burst_last", int'(data_out), 8'hEE);

    // flush with one byte on the wire and five queued
    for (int i = 0; i < 6; i++) put(8'hB0 + DW'(i));
    n = 0;
    while (tx_ready && n < 50) begin cyc(); n++; end
    chk("flush_tx_busy", int'(tx_ready), 0);
    cyc(); cyc();
    chk("flush_pre_count", int'(count), 5);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_count", int'(count), 0);
    chk("flush_dout_kept", int'(data_out), 8'hB0);
    wait_idle(200);
    chk("flush_idle", int'(idle), 1);

    // flush coinciding with a start condition
    tx_hold = 1'b1;
    cyc();
    put(8'h11); put(8'h22);
    flush = 1'b1; tx_hold = 1'b0;
    cyc();
    flush = 1'b0;
    chk("flush_win_send", int'(send), 0);
    chk("flush_win_count", int'(count), 0);
    cyc(); cyc();

    // reset while waiting for the transmitter to go busy, three bytes queued
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'hC0 + DW'(i);
      cyc();
    end
    wr_en = 1'b0;
    chk("prerst_count", int'(count), 3);
    chk("prerst_dout", int'(data_out), 8'hC0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_send", int'(send), 0);
    chk("mid_rst_dout", int'(data_out), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_idle", int'(idle), 1);
    chk("mid_rst_full", int'(full), 0);
    cyc(); cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    put(8'h3C);
    cyc();
    chk("post_rst_send", int'(send), 1);
    chk("post_rst_dout", int'(data_out), 8'h3C);
    wait_idle(200);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      wr_en   = ($urandom % 3) == 0;
      b       = DW'($urandom);
      wr_data = b;
      clr_ovf = ($urandom % 16) == 0;
      flush   = ($urandom % 64) == 0;
      if (($urandom % 20) == 0) tx_hold = !tx_hold;
      cyc();
    end
    wr_en = 1'b0; clr_ovf = 1'b0; flush = 1'b0; tx_hold = 1'b0;
    wait_idle(800);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
